// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, default
// widths and the halt-marker instruction word.
package fetch_pkg;

  localparam int DEFAULT_PC_WIDTH    = 8;
  localparam int DEFAULT_INSTR_WIDTH = 32;
  localparam int DEFAULT_COUNT_WIDTH = 16;

  // All-ones word marks end of program when halt detection is built in.
  localparam logic [DEFAULT_INSTR_WIDTH-1:0] HALT_WORD = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetchState_e;

endpackage

// File: rtl/fetch_output_stage.sv
// One-entry valid/ready output register between fetch and decode.
// Priority: flush > load > drain-on-transfer. Data holds while stalled.
module fetch_output_stage
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   load,
  input  logic [INSTR_WIDTH-1:0] loadInstr,
  input  logic [PC_WIDTH-1:0]    loadPc,
  input  logic                   decodeReady,
  output logic                   instrValid,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic [PC_WIDTH-1:0]    instrPc,
  output logic                   transfer
);

  // A word moves to decode whenever it is valid and decode is ready.
  assign transfer = instrValid && decodeReady;

  // Capture, flush or drain the held word.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    if (reset) begin
      // NOTE: the data registers are reset too, not just the valid bit, so the
      // outputs show a defined zero word and zero pc straight out of reset.
      instrValid <= 1'b0;
      instrOut   <= '0;
      instrPc    <= '0;
    end else if (flush) begin
      instrValid <= 1'b0;
    end else if (load) begin
      instrValid <= 1'b1;
      instrOut   <= loadInstr;
      instrPc    <= loadPc;
    end else if (transfer) begin
      instrValid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the program counter, the IDLE/RUN/HALT FSM and the
// accepted-word counter; the held word lives in fetch_output_stage.
// Optional build macro: FETCH_HALT_DETECT_EN (all-ones word stops fetching).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = DEFAULT_PC_WIDTH,
  parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
  parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic [INSTR_WIDTH-1:0] imemInstr,
  output logic                   instrValid,
  input  logic                   decodeReady,
  output logic [INSTR_WIDTH-1:0] instrOut,
  output logic [PC_WIDTH-1:0]    instrPc,
  input  logic                   redirectValid,
  input  logic [PC_WIDTH-1:0]    redirectTarget,
  output logic [COUNT_WIDTH-1:0] fetchCount,
  output logic                   halted
);

  fetchState_e          state;
  fetchState_e          stateNext;
  logic [PC_WIDTH-1:0]  pc;
  logic [PC_WIDTH-1:0]  pcNext;
  logic                 load;
  logic                 flush;
  logic                 transfer;

  assign imemAddr = pc;

  // State, pc and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= '0;
      fetchCount <= '0;
    end else begin
      state <= stateNext;
      pc    <= pcNext;
      if (transfer) begin
        fetchCount <= fetchCount + COUNT_WIDTH'(1);
      end
    end
  end

  // Next-state, next-pc and output-stage controls; redirect beats load/stall.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    stateNext = state;
    pcNext    = pc;
    load      = 1'b0;
    flush     = 1'b0;
    case (state)
      IDLE: begin
        if (redirectValid) begin
          pcNext = redirectTarget;
        end
        if (start) begin
          stateNext = RUN;
        end
      end
      RUN: begin
        if (redirectValid) begin
          pcNext = redirectTarget;
          flush  = 1'b1;
        end else if (!instrValid || decodeReady) begin
          load = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
          if (imemInstr == {INSTR_WIDTH{1'b1}}) begin
            stateNext = HALT;
          end else begin
            pcNext = pc + PC_WIDTH'(1);
          end
`else
          pcNext = pc + PC_WIDTH'(1);
`endif
        end
      end
      HALT: begin
        if (redirectValid) begin
          pcNext    = redirectTarget;
          flush     = 1'b1;
          stateNext = RUN;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

`ifdef FETCH_HALT_DETECT_EN
  assign halted = (state == HALT);
`else
  assign halted = 1'b0;
`endif

  fetch_output_stage #(
    .PC_WIDTH    (PC_WIDTH),
    .INSTR_WIDTH (INSTR_WIDTH)
  ) outputStage (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .load        (load),
    .loadInstr   (imemInstr),
    .loadPc      (pc),
    .decodeReady (decodeReady),
    .instrValid  (instrValid),
    .instrOut    (instrOut),
    .instrPc     (instrPc),
    .transfer    (transfer)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; imem model holds imem[i] = i.
// Halt checks follow the FETCH_HALT_DETECT_EN setting of the build.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  imemAddr;
  logic [31:0] imemInstr;
  logic        instrValid;
  logic        decodeReady;
  logic [31:0] instrOut;
  logic [7:0]  instrPc;
  logic        redirectValid;
  logic [7:0]  redirectTarget;
  logic [15:0] fetchCount;
  logic        halted;

  logic [31:0] imem [256];
  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  assign imemInstr = imem[imemAddr];

  fetch_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .imemAddr       (imemAddr),
    .imemInstr      (imemInstr),
    .instrValid     (instrValid),
    .decodeReady    (decodeReady),
    .instrOut       (instrOut),
    .instrPc        (instrPc),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .fetchCount     (fetchCount),
    .halted         (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    check({tag, ".valid"}, 32'(instrValid), 32'd0);
    check({tag, ".addr"},  32'(imemAddr),   32'd0);
    check({tag, ".pc"},    32'(instrPc),    32'd0);
    check({tag, ".instr"}, instrOut,        32'd0);
    check({tag, ".count"}, 32'(fetchCount), 32'd0);
    check({tag, ".halted"}, 32'(halted),    32'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 32'(i);
    reset = 1'b1; start = 1'b0; decodeReady = 1'b1;
    redirectValid = 1'b0; redirectTarget = 8'h00;
    tick(); tick();
    reset = 1'b0;
    checkResetState("reset");

    // 1: start, full throughput from address 0
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t1.addr0", 32'(imemAddr), 32'd0);
    check("t1.valid0", 32'(instrValid), 32'd0);
    tick();
    check("t1.validFirst", 32'(instrValid), 32'd1);
    check("t1.pcFirst", 32'(instrPc), 32'd0);
    check("t1.countFirst", 32'(fetchCount), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check("t1.pc", 32'(instrPc), 32'(k));
      check("t1.instr", instrOut, 32'(k));
      check("t1.count", 32'(fetchCount), 32'(k));
    end

    // 2: three stall cycles holding word 5
    decodeReady = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2.valid", 32'(instrValid), 32'd1);
      check("t2.pc", 32'(instrPc), 32'd5);
      check("t2.instr", instrOut, 32'd5);
      check("t2.addr", 32'(imemAddr), 32'd6);
      check("t2.count", 32'(fetchCount), 32'd5);
    end
    decodeReady = 1'b1;
    tick();
    check("t2.resumePc", 32'(instrPc), 32'd6);
    check("t2.resumeCount", 32'(fetchCount), 32'd6);
    check("t2.resumeAddr", 32'(imemAddr), 32'd7);

    // 3: redirect to 0x40 during a stall at pc 7
    decodeReady = 1'b0;
    redirectValid = 1'b1; redirectTarget = 8'h40;
    tick();
    redirectValid = 1'b0; decodeReady = 1'b1;
    check("t3.flushValid", 32'(instrValid), 32'd0);
    check("t3.addr", 32'(imemAddr), 32'h40);
    check("t3.count", 32'(fetchCount), 32'd6);
    tick();
    check("t3.valid", 32'(instrValid), 32'd1);
    check("t3.pc", 32'(instrPc), 32'h40);
    check("t3.instr", instrOut, 32'h40);
    tick();
    check("t3.nextPc", 32'(instrPc), 32'h41);
    check("t3.nextCount", 32'(fetchCount), 32'd7);

    // redirect together with a completing transfer still counts the word
    redirectValid = 1'b1; redirectTarget = 8'hFE;
    tick();
    redirectValid = 1'b0;
    check("rt.valid", 32'(instrValid), 32'd0);
    check("rt.count", 32'(fetchCount), 32'd8);
    check("rt.addr", 32'(imemAddr), 32'hFE);

    // 4: pc wrap 0xFE, 0xFF, 0x00
    tick();
    check("t4.pcFE", 32'(instrPc), 32'hFE);
    check("t4.instrFE", instrOut, 32'hFE);
    tick();
    check("t4.pcFF", 32'(instrPc), 32'hFF);
    tick();
    check("t4.pc00", 32'(instrPc), 32'h00);
    check("t4.addr01", 32'(imemAddr), 32'h01);
    check("t4.count", 32'(fetchCount), 32'd10);

    // 5: reset mid-RUN with a valid word held
    check("t5.preValid", 32'(instrValid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkResetState("t5");
    tick();
    check("t5.idleValid", 32'(instrValid), 32'd0);
    check("t5.idleAddr", 32'(imemAddr), 32'd0);

    // IDLE redirect moves pc only; start with redirect takes the target
    redirectValid = 1'b1; redirectTarget = 8'h10;
    tick();
    redirectValid = 1'b0;
    check("idle.addr", 32'(imemAddr), 32'h10);
    tick();
    check("idle.noCapture", 32'(instrValid), 32'd0);
    start = 1'b1; redirectValid = 1'b1; redirectTarget = 8'h20;
    tick();
    start = 1'b0; redirectValid = 1'b0;
    check("startRd.addr", 32'(imemAddr), 32'h20);
    check("startRd.valid", 32'(instrValid), 32'd0);
    tick();
    check("startRd.pc", 32'(instrPc), 32'h20);
    check("startRd.validOn", 32'(instrValid), 32'd1);

    // 6: all-ones word at address 3
    imem[3] = HALT_WORD;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("t6.pc3", 32'(instrPc), 32'd3);
    check("t6.instr3", instrOut, HALT_WORD);
    check("t6.count", 32'(fetchCount), 32'd3);
`ifdef FETCH_HALT_DETECT_EN
    check("t6.halted", 32'(halted), 32'd1);
    check("t6.addrHold", 32'(imemAddr), 32'd3);
    tick();
    check("t6.drained", 32'(instrValid), 32'd0);
    check("t6.drainCount", 32'(fetchCount), 32'd4);
    check("t6.addrStill", 32'(imemAddr), 32'd3);
    tick();
    check("t6.noLoad", 32'(instrValid), 32'd0);
    check("t6.stillHalted", 32'(halted), 32'd1);
    redirectValid = 1'b1; redirectTarget = 8'h00;
    tick();
    redirectValid = 1'b0;
    check("t6.resumeHalted", 32'(halted), 32'd0);
    check("t6.resumeAddr", 32'(imemAddr), 32'd0);
    tick();
    check("t6.resumeValid", 32'(instrValid), 32'd1);
    check("t6.resumePc", 32'(instrPc), 32'd0);
`else
    check("t6.halted", 32'(halted), 32'd0);
    check("t6.addrAdv", 32'(imemAddr), 32'd4);
    tick();
    check("t6.pc4", 32'(instrPc), 32'd4);
    check("t6.count4", 32'(fetchCount), 32'd4);
    check("t6.haltedStill", 32'(halted), 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
